// File: rtl/md_sequencer.sv
// md_sequencer: issues start pulses to the multi-cycle mult/div unit, stalls EX until it
// finishes, then presents the result and exception flag for exactly one cycle.
//
// Parameters:
//   TIMEOUT_CYCLES - BUSY cycles without md_ready before the watchdog gives up
//   CNT_W          - BUSY counter width, 2**CNT_W must exceed TIMEOUT_CYCLES
//
// Ports:
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   ir_ex, op_a, op_b     - EX instruction and its rs/rt operand values
//   flush                 - pipeline kill (taken branch / jump)
//   md_ready, md_result,
//   md_exception          - completion handshake from the mult/div unit
//   ctrl_mult, ctrl_div   - one-cycle start pulses to the unit
//   md_op_a, md_op_b      - operands held for the unit from START onward
//   stall                 - freezes PC, FD, DX and holds EX
//   result_valid, md_out,
//   md_exc                - captured result, valid for one cycle in DONE
//
// Build option:
//   MD_TIMEOUT_EN - when defined, a BUSY phase that reaches TIMEOUT_CYCLES without md_ready
//                   ends in DONE with md_out=0 and md_exc=1. Without it, BUSY waits forever.

module md_sequencer #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ir_ex,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  input  logic        md_ready,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic [31:0] md_op_a,
  output logic [31:0] md_op_b,
  output logic        stall,
  output logic        result_valid,
  output logic [31:0] md_out,
  output logic        md_exc
);

`ifdef MD_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic is_rtype;
  logic is_mult;
  logic is_div;
  logic is_md;
  logic issue;
  logic timeout;

  assign is_rtype = ir_ex[31:27] == 5'b00000;
  assign is_mult  = is_rtype && (ir_ex[6:2] == 5'b00110);
  assign is_div   = is_rtype && (ir_ex[6:2] == 5'b00111);
  assign is_md    = is_mult || is_div;

  assign issue = (state == IDLE) && is_md && !flush;

  // The IDLE term stalls in the same cycle the op is seen, so EX
  // holds the instruction while START is being entered.
  assign stall = issue
              || (state == START)
              || (state == BUSY);

  // cnt counts completed BUSY cycles; on the BUSY cycle where it
  // equals TIMEOUT_CYCLES-1 the TIMEOUT_CYCLES-th idle cycle ends.
  assign timeout = TIMEOUT_EN && (cnt >= TO_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      ctrl_mult    <= 1'b0;
      ctrl_div     <= 1'b0;
      md_op_a      <= '0;
      md_op_b      <= '0;
      result_valid <= 1'b0;
      md_out       <= '0;
      md_exc       <= 1'b0;
    end else begin
      ctrl_mult    <= 1'b0;
      ctrl_div     <= 1'b0;
      result_valid <= 1'b0;

      unique case (state)
        IDLE: begin
          if (issue) begin
            state     <= START;
            md_op_a   <= op_a;
            md_op_b   <= op_b;
            // Registered here so the pulse is high for the START
            // cycle only; the op type rides in these two flops.
            ctrl_mult <= is_mult;
            ctrl_div  <= is_div;
          end
        end

        START: begin
          // The unit cannot answer yet, so md_ready is not looked at.
          cnt   <= '0;
          state <= flush ? IDLE : BUSY;
        end

        BUSY: begin
          if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
          // A kill wins over a same-cycle completion; the result is
          // dropped and md_out/md_exc keep their previous values.
          if (flush) begin
            state <= IDLE;
          end else if (md_ready) begin
            state        <= DONE;
            md_out       <= md_result;
            md_exc       <= md_exception;
            result_valid <= 1'b1;
          end else if (timeout) begin
            state        <= DONE;
            md_out       <= '0;
            md_exc       <= 1'b1;
            result_valid <= 1'b1;
          end
        end

        DONE: begin
          // result_valid is already registered high for this cycle,
          // even if flush is asserted; the consumer discards it.
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Testbench for md_sequencer: directed test-plan cases plus randomized
// traffic, with expectations queued by the driver and popped by a monitor.

`timescale 1ns/1ps

module tb_md_sequencer;

  localparam int         TO_CYC = 40;
  localparam logic [4:0] MUL_F  = 5'b00110;
  localparam logic [4:0] DIV_F  = 5'b00111;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ir_ex;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        md_ready;
  logic [31:0] md_result;
  logic        md_exception;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic [31:0] md_op_a;
  logic [31:0] md_op_b;
  logic        stall;
  logic        result_valid;
  logic [31:0] md_out;
  logic        md_exc;

  // Directed stimulus and the behavioural unit model drive separate
  // copies; auto_unit selects which one reaches the DUT.
  bit          auto_unit = 1'b0;
  logic        d_ready = 1'b0;
  logic [31:0] d_result = '0;
  logic        d_exc = 1'b0;
  logic        u_ready = 1'b0;
  logic [31:0] u_result = '0;
  logic        u_exc = 1'b0;

  assign md_ready     = auto_unit ? u_ready  : d_ready;
  assign md_result    = auto_unit ? u_result : d_result;
  assign md_exception = auto_unit ? u_exc    : d_exc;

  md_sequencer #(
    .TIMEOUT_CYCLES(TO_CYC),
    .CNT_W(6)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ir_ex(ir_ex),
    .op_a(op_a),
    .op_b(op_b),
    .flush(flush),
    .md_ready(md_ready),
    .md_result(md_result),
    .md_exception(md_exception),
    .ctrl_mult(ctrl_mult),
    .ctrl_div(ctrl_div),
    .md_op_a(md_op_a),
    .md_op_b(md_op_b),
    .stall(stall),
    .result_valid(result_valid),
    .md_out(md_out),
    .md_exc(md_exc)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [64:0] start_q[$];
  logic [32:0] res_q[$];

  task automatic chkw(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chkw(name, {64'd0, act}, {64'd0, exp});
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    chkw(name, {33'd0, act}, {33'd0, exp});
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Mult/div semantics: {exception, result}.
  // mult: low 32 bits of the signed product, exception on signed overflow.
  // div: signed quotient; divide-by-zero or MIN/-1 raise the exception.
  function automatic logic [32:0] md_ref(input logic dv, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     ia;
    int     ib;
    int     q;
    logic [31:0] lo;
    if (!dv) begin
      p  = longint'(signed'(a)) * longint'(signed'(b));
      lo = p[31:0];
      return {p != longint'(signed'(lo)), lo};
    end
    if (b == 32'd0) return {1'b1, 32'd0};
    if (a == 32'h8000_0000 && b == 32'hffff_ffff) return {1'b1, 32'h8000_0000};
    ia = a;
    ib = b;
    q  = ia / ib;
    return {1'b0, q};
  endfunction

  function automatic logic [31:0] enc(input logic [4:0] f);
    logic [31:0] r;
    r        = $urandom;
    r[31:27] = 5'b00000;
    r[6:2]   = f;
    return r;
  endfunction

  function automatic logic [31:0] enc_other();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 1) == 1) r[31:27] = 5'b00000;
    if (r[31:27] == 5'b00000 && r[6:3] == 4'b0011) r[3] = 1'b0;
    return r;
  endfunction

  // Behavioural mult/div unit: answers 1..5 BUSY cycles after START
  // using the operands the DUT latched.
  logic [32:0] u_r;
  int          u_lat;
  initial begin
    forever begin
      @(negedge clock);
      if (auto_unit && !reset && (ctrl_mult || ctrl_div)) begin
        u_r   = md_ref(ctrl_div, md_op_a, md_op_b);
        u_lat = $urandom_range(1, 5);
        repeat (u_lat) @(posedge clock);
        #1;
        u_ready  = 1'b1;
        u_result = u_r[31:0];
        u_exc    = u_r[32];
        @(posedge clock);
        #1;
        u_ready  = 1'b0;
        u_result = $urandom;
        u_exc    = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: pops queued expectations whenever the DUT starts an op or
  // presents a result.
  logic [64:0] exp_s;
  logic [32:0] exp_r;
  logic        rv_prev = 1'b0;
  logic        ct_prev = 1'b0;
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        rv_prev = 1'b0;
        ct_prev = 1'b0;
      end else begin
        if (ctrl_mult || ctrl_div) begin
          chk1("ctrl_exclusive", ctrl_mult && ctrl_div, 1'b0);
          chk1("ctrl_one_cycle", ct_prev, 1'b0);
          chk1("start_expected", start_q.size() > 0, 1'b1);
          if (start_q.size() > 0) begin
            exp_s = start_q.pop_front();
            chkw("start_op", {ctrl_div, md_op_a, md_op_b}, exp_s);
          end
        end
        if (result_valid) begin
          chk1("rv_one_cycle", rv_prev, 1'b0);
          chk1("result_expected", res_q.size() > 0, 1'b1);
          if (res_q.size() > 0) begin
            exp_r = res_q.pop_front();
            chkw("result", {32'd0, md_exc, md_out}, {32'd0, exp_r});
          end
        end
        rv_prev = result_valid;
        ct_prev = ctrl_mult || ctrl_div;
      end
    end
  end

  // Runs one op with md_ready on BUSY cycle rdy_at (1-based). Cycle c=0
  // is the cycle the op sits in EX with the sequencer idle.
  task automatic run_op(
    input  logic        dv,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  int          rdy_at,
    input  logic [31:0] r,
    input  logic        e,
    input  bit          chain,
    output int          n_st,
    output int          n_cm,
    output int          n_cd,
    output int          n_rv,
    output int          rv_at,
    output int          rv_cyc,
    output int          st_cyc
  );
    int last_c;
    n_st   = 0;
    n_cm   = 0;
    n_cd   = 0;
    n_rv   = 0;
    rv_at  = -1;
    rv_cyc = -1;
    st_cyc = -1;
    last_c = chain ? rdy_at + 3 : rdy_at + 6;
    ir_ex  = enc(dv ? DIV_F : MUL_F);
    op_a   = a;
    op_b   = b;
    start_q.push_back({dv, a, b});
    res_q.push_back({e, r});
    for (int c = 0; c < last_c; c++) begin
      d_ready  = (c == rdy_at + 1);
      d_result = (c == rdy_at + 1) ? r : $urandom;
      d_exc    = (c == rdy_at + 1) ? e : ~e;
      if (c > 0) begin
        op_a = $urandom;
        op_b = $urandom;
      end
      if (c == rdy_at + 3) ir_ex = enc_other();
      @(negedge clock);
      n_st += int'(stall);
      n_cm += int'(ctrl_mult);
      n_cd += int'(ctrl_div);
      if (ctrl_mult || ctrl_div) st_cyc = cyc;
      if (result_valid) begin
        n_rv++;
        if (rv_at < 0) begin
          rv_at  = c;
          rv_cyc = cyc;
        end
      end
      @(posedge clock);
      #1;
    end
    d_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  int          ns, ncm, ncd, nrv, rvat, rvcyc, stcyc, rvcyc1, k, w, cnt;
  logic        dv;
  logic [31:0] a, b;
  logic [31:0] last_out;
  logic        last_exc;

  initial begin
    reset = 1'b1;
    ir_ex = 32'd0;
    op_a  = 32'd0;
    op_b  = 32'd0;
    flush = 1'b0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk1("rst_ctrl_mult", ctrl_mult, 1'b0);
    chk1("rst_ctrl_div", ctrl_div, 1'b0);
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_result_valid", result_valid, 1'b0);
    chk1("rst_md_exc", md_exc, 1'b0);
    chk32("rst_md_out", md_out, 32'd0);
    chk32("rst_md_op_a", md_op_a, 32'd0);
    chk32("rst_md_op_b", md_op_b, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // mult 6*7, ready on the 3rd BUSY cycle
    run_op(1'b0, 32'd6, 32'd7, 3, 32'd42, 1'b0, 1'b0, ns, ncm, ncd, nrv, rvat, rvcyc, stcyc);
    chki("mult_stall_cycles", ns, 5);
    chki("mult_ctrl_mult_pulses", ncm, 1);
    chki("mult_ctrl_div_pulses", ncd, 0);
    chki("mult_rv_pulses", nrv, 1);
    chki("mult_rv_cycle", rvat, 5);

    // div 10/0 with exception
    run_op(1'b1, 32'd10, 32'd0, 2, 32'd0, 1'b1, 1'b0, ns, ncm, ncd, nrv, rvat, rvcyc, stcyc);
    chki("div_ctrl_mult_pulses", ncm, 0);
    chki("div_ctrl_div_pulses", ncd, 1);
    chki("div_rv_pulses", nrv, 1);
    chki("div_rv_cycle", rvat, 4);

    // back-to-back mult then div
    run_op(1'b0, 32'd3, 32'd4, 1, 32'd12, 1'b0, 1'b1, ns, ncm, ncd, nrv, rvat, rvcyc, stcyc);
    chki("b2b_first_rv_pulses", nrv, 1);
    chki("b2b_min_latency", rvat, 3);
    rvcyc1 = rvcyc;
    run_op(1'b1, 32'd100, 32'd7, 2, 32'd14, 1'b0, 1'b0, ns, ncm, ncd, nrv, rvat, rvcyc, stcyc);
    chki("b2b_div_start_gap", stcyc - rvcyc1, 2);
    chki("b2b_second_rv_pulses", nrv, 1);
    last_out = 32'd14;
    last_exc = 1'b0;

    // flush on the 2nd BUSY cycle, late md_ready one cycle after
    ir_ex = enc(MUL_F);
    op_a  = 32'd3;
    op_b  = 32'd5;
    start_q.push_back({1'b0, 32'd3, 32'd5});
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush    = 1'b0;
    ir_ex    = enc_other();
    d_ready  = 1'b1;
    d_result = 32'hdead_beef;
    d_exc    = 1'b1;
    @(negedge clock);
    chk1("flush_stall_drop", stall, 1'b0);
    chk1("flush_no_rv", result_valid, 1'b0);
    @(posedge clock);
    #1;
    d_ready = 1'b0;
    @(negedge clock);
    chk1("flush_late_ready_no_rv", result_valid, 1'b0);
    chk32("flush_md_out_kept", md_out, last_out);
    chk1("flush_md_exc_kept", md_exc, last_exc);
    @(posedge clock);
    #1;

    // reset while BUSY
    ir_ex = enc(MUL_F);
    op_a  = 32'd9;
    op_b  = 32'd9;
    start_q.push_back({1'b0, 32'd9, 32'd9});
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    ir_ex = enc_other();
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk1("midrst_ctrl_mult", ctrl_mult, 1'b0);
    chk1("midrst_ctrl_div", ctrl_div, 1'b0);
    chk1("midrst_stall", stall, 1'b0);
    chk1("midrst_result_valid", result_valid, 1'b0);
    chk1("midrst_md_exc", md_exc, 1'b0);
    chk32("midrst_md_out", md_out, 32'd0);
    chk32("midrst_md_op_a", md_op_a, 32'd0);
    chk32("midrst_md_op_b", md_op_b, 32'd0);
    @(posedge clock);
    #1;

    // sequencer must be idle again: minimum-latency op goes straight through
    run_op(1'b0, 32'hffff_fffe, 32'd5, 1, 32'hffff_fff6, 1'b0, 1'b0,
           ns, ncm, ncd, nrv, rvat, rvcyc, stcyc);
    chki("postrst_latency", rvat, 3);
    chki("postrst_stall_cycles", ns, 3);

`ifdef MD_TIMEOUT_EN
    // md_ready never comes: watchdog ends BUSY after TO_CYC cycles
    ir_ex = enc(MUL_F);
    op_a  = 32'd1;
    op_b  = 32'd2;
    start_q.push_back({1'b0, 32'd1, 32'd2});
    res_q.push_back({1'b1, 32'd0});
    cnt  = 0;
    nrv  = 0;
    rvat = -1;
    for (int c = 0; c < TO_CYC + 6; c++) begin
      d_ready  = (c == TO_CYC + 3);
      d_result = $urandom;
      d_exc    = 1'b0;
      if (c == TO_CYC + 3) ir_ex = enc_other();
      @(negedge clock);
      cnt += int'(stall);
      if (result_valid) begin
        nrv++;
        if (rvat < 0) rvat = c;
      end
      @(posedge clock);
      #1;
    end
    d_ready = 1'b0;
    chki("timeout_stall_cycles", cnt, TO_CYC + 2);
    chki("timeout_rv_cycle", rvat, TO_CYC + 2);
    chki("timeout_rv_pulses", nrv, 1);
`else
    // md_ready never comes: BUSY holds the pipeline indefinitely
    ir_ex = enc(MUL_F);
    op_a  = 32'd1;
    op_b  = 32'd2;
    start_q.push_back({1'b0, 32'd1, 32'd2});
    cnt = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clock);
      cnt += int'(stall);
      @(posedge clock);
      #1;
    end
    chki("no_timeout_stall_cycles", cnt, 120);
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    ir_ex = enc_other();
    @(negedge clock);
    chk1("no_timeout_flush_release", stall, 1'b0);
    @(posedge clock);
    #1;
`endif

    // randomized traffic against the behavioural unit
    auto_unit = 1'b1;
    for (int n = 0; n < 200; n++) begin
      k = $urandom_range(0, 9);
      if (k < 2) begin
        ir_ex = enc_other();
        op_a  = $urandom;
        op_b  = $urandom;
        @(negedge clock);
        chk1("rand_nop_stall", stall, 1'b0);
        @(posedge clock);
        #1;
      end else if (k == 2) begin
        ir_ex = enc(($urandom_range(0, 1) == 1) ? DIV_F : MUL_F);
        op_a  = $urandom;
        op_b  = $urandom;
        flush = 1'b1;
        @(negedge clock);
        chk1("rand_killed_stall", stall, 1'b0);
        @(posedge clock);
        #1;
        flush = 1'b0;
      end else begin
        dv = 1'($urandom_range(0, 1));
        k  = $urandom_range(0, 7);
        b  = (k == 0) ? 32'd0 :
             (k == 1) ? 32'hffff_ffff :
             (k < 4)  ? 32'($urandom_range(1, 20)) : 32'($urandom);
        a  = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : 32'($urandom);
        ir_ex = enc(dv ? DIV_F : MUL_F);
        op_a  = a;
        op_b  = b;
        start_q.push_back({dv, a, b});
        res_q.push_back(md_ref(dv, a, b));
        w = 0;
        @(negedge clock);
        while (stall && w < 40) begin
          @(posedge clock);
          #1;
          op_a = $urandom;
          op_b = $urandom;
          @(negedge clock);
          w++;
        end
        chk1("rand_op_completes", stall, 1'b0);
        @(posedge clock);
        #1;
      end
    end

    auto_unit = 1'b0;
    ir_ex     = enc_other();
    repeat (6) @(posedge clock);
    @(negedge clock);
    chki("start_q_drained", start_q.size(), 0);
    chki("res_q_drained", res_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
